banco_sensores: RTL and testbench
=================================

Name: banco_sensores

Overview:
- Parametrised bank of N independent debounced sensor inputs.
- Generalises the two-button sensor front end with a configurable channel count and stability window.
- Adds an external sample strobe, registered rising/falling-edge pulses per channel, and a saturating counter of rejected bounces.
- Sits between the raw pads and the control FSMs, which consume the clean levels and the single-cycle edge pulses.

Parameters:
N_CANALES, 2, number of sensor channels (>=1)
CICLOS_ESTABLE, 500000, consecutive sample strobes a new level must persist before acceptance (>=1); 10 ms at 50 MHz with muestreo tied high
NIVEL_REPOSO, 1'b0, idle level loaded into synchronisers and stable outputs at reset

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
entradas  input  N_CANALES  raw asynchronous sensor/button signals
muestreo  input  1  sample strobe; debounce counters advance only when high; tie high for per-cycle operation
limpiar_rebotes  input  1  synchronous clear of cuenta_rebotes
estables  output  N_CANALES  debounced levels, registered
flanco_subida  output  N_CANALES  one-cycle pulse when estables[i] goes 0->1
flanco_bajada  output  N_CANALES  one-cycle pulse when estables[i] goes 1->0
cuenta_rebotes  output  16  saturating count of aborted transitions

Behaviour:
- Reset (synchronous, highest priority):
  - Both synchroniser stages and estables are set to NIVEL_REPOSO on all channels.
  - All per-channel counters, flanco_subida, flanco_bajada and cuenta_rebotes are set to 0.
  - Reset asserted mid-count discards the pending transition; no edge pulse is generated.
- Per channel: 2-FF synchroniser s1 <= entradas[i], s2 <= s1. It runs every cycle, independent of muestreo.
- Per-channel counter cnt, width $clog2(CICLOS_ESTABLE+1). Per cycle, in priority order:
  - s2 == estables[i]: cnt <= 0. If cnt was non-zero, flag an aborted transition for that channel.
  - s2 != estables[i] and muestreo == 0: hold cnt and estables.
  - s2 != estables[i], muestreo == 1, cnt < CICLOS_ESTABLE-1: cnt <= cnt+1.
  - s2 != estables[i], muestreo == 1, cnt == CICLOS_ESTABLE-1: estables[i] <= s2, cnt <= 0, and the matching edge output is asserted for exactly that one cycle.
- Latency with muestreo tied high: a step on entradas sampled at edge E0 appears on estables at edge E0+CICLOS_ESTABLE+1. The edge pulse is asserted in the same cycle estables changes.
- flanco_subida and flanco_bajada are zero in every cycle without an accepted transition. Both are never high for the same channel in the same cycle.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulses in the same cycle.
- cuenta_rebotes, in priority order:
  - reset: cleared.
  - limpiar_rebotes: cleared (wins over a same-cycle abort).
  - Otherwise +1 in any cycle where one or more channels flag an abort. Multiple channels aborting in one cycle count as 1.
  - Saturates at 16'hFFFF with no wrap.
- A level that returns to estables before acceptance never alters estables or the edge outputs.

Test Plan:
- Config for all scenarios: N_CANALES=2, CICLOS_ESTABLE=4, muestreo high unless stated.
- Reset: hold reset for 3 cycles with entradas=2'b11 -> estables=00, no pulses, cuenta_rebotes=0. After release, estables[1:0]=11 at edge 5 after the first sampling edge; flanco_subida=11 for exactly 1 cycle.
- Clean step: entradas[0] 0->1 sampled at E0 and held -> estables[0]=1 at E0+5; flanco_subida[0] high only in that cycle; channel 1 untouched.
- Bounce: entradas[0] high for 3 cycles, then low -> estables[0] stays 0, no pulses, cuenta_rebotes=1. Repeat on both channels in the same cycle -> cuenta_rebotes=2.
- Strobe gating: muestreo high every 2nd cycle, clean 1->0 step on channel 1 -> acceptance after 4 strobe-high cycles; flanco_bajada[1] single pulse; no change while muestreo is low.
- Clear/saturation: preload to 16'hFFFE via bounces, then 2 more aborts -> value holds at FFFF. Assert limpiar_rebotes in the same cycle as an abort -> 0.
- Reset mid-count: assert reset when cnt=2 on a pending rise -> estables=0, no pulse; the pending count restarts from 0 after release.

Source files
------------

// File: rtl/banco_sensores.sv
// Bank of N debounced sensor inputs: 2-FF synchroniser, strobe-gated stability counter,
// registered edge pulses per channel and a saturating count of aborted transitions.
module banco_sensores #(
  parameter int   N_CANALES      = 2,
  parameter int   CICLOS_ESTABLE = 500000,
  parameter logic NIVEL_REPOSO   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CANALES-1:0] entradas,
  input  logic                 muestreo,
  input  logic                 limpiar_rebotes,
  output logic [N_CANALES-1:0] estables,
  output logic [N_CANALES-1:0] flanco_subida,
  output logic [N_CANALES-1:0] flanco_bajada,
  output logic [15:0]          cuenta_rebotes
);

  localparam int             CW      = $clog2(CICLOS_ESTABLE + 1);
  localparam logic [CW-1:0]  CNT_FIN = CW'(CICLOS_ESTABLE - 1);
  localparam logic [CW-1:0]  CNT_UNO = CW'(1);

  logic [N_CANALES-1:0]         s1_q, s2_q;
  logic [N_CANALES-1:0]         estables_q, estables_d;
  logic [N_CANALES-1:0]         subida_q, subida_d;
  logic [N_CANALES-1:0]         bajada_q, bajada_d;
  logic [N_CANALES-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N_CANALES-1:0]         aborto;
  logic [15:0]                  cuenta_q, cuenta_d;

  always_comb begin
    estables_d = estables_q;
    cnt_d      = cnt_q;
    subida_d   = '0;
    bajada_d   = '0;
    aborto     = '0;
    for (int i = 0; i < N_CANALES; i++) begin
      if (s2_q[i] == estables_q[i]) begin
        // Level fell back before acceptance: a non-zero count means a bounce.
        cnt_d[i]  = '0;
        aborto[i] = (cnt_q[i] != '0);
      end else if (muestreo) begin
        if (cnt_q[i] == CNT_FIN) begin
          estables_d[i] = s2_q[i];
          cnt_d[i]      = '0;
          subida_d[i]   = s2_q[i];
          bajada_d[i]   = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_UNO;
        end
      end
    end
  end

  always_comb begin
    cuenta_d = cuenta_q;
    if (limpiar_rebotes) begin
      cuenta_d = '0;
    end else if ((|aborto) && (cuenta_q != 16'hFFFF)) begin
      cuenta_d = cuenta_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= {N_CANALES{NIVEL_REPOSO}};
      s2_q       <= {N_CANALES{NIVEL_REPOSO}};
      estables_q <= {N_CANALES{NIVEL_REPOSO}};
      cnt_q      <= '0;
      subida_q   <= '0;
      bajada_q   <= '0;
      cuenta_q   <= '0;
    end else begin
      s1_q       <= entradas;
      s2_q       <= s1_q;
      estables_q <= estables_d;
      cnt_q      <= cnt_d;
      subida_q   <= subida_d;
      bajada_q   <= bajada_d;
      cuenta_q   <= cuenta_d;
    end
  end

  assign estables       = estables_q;
  assign flanco_subida  = subida_q;
  assign flanco_bajada  = bajada_q;
  assign cuenta_rebotes = cuenta_q;

endmodule

// File: tb/tb_banco_sensores.sv
// Directed bench for banco_sensores with N_CANALES=2, CICLOS_ESTABLE=4.
module tb_banco_sensores;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  entradas;
  logic        muestreo;
  logic        limpiar_rebotes;
  logic [1:0]  estables, flanco_subida, flanco_bajada;
  logic [15:0] cuenta_rebotes;

  int n_cmp = 0;
  int n_err = 0;

  banco_sensores #(
    .N_CANALES(2),
    .CICLOS_ESTABLE(4),
    .NIVEL_REPOSO(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .entradas(entradas),
    .muestreo(muestreo),
    .limpiar_rebotes(limpiar_rebotes),
    .estables(estables),
    .flanco_subida(flanco_subida),
    .flanco_bajada(flanco_bajada),
    .cuenta_rebotes(cuenta_rebotes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ent;
    logic        m;
    logic        clr;
    logic        rst;
    logic [1:0]  e_est;
    logic [1:0]  e_sub;
    logic [1:0]  e_baj;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tab[$];

  task automatic push(input int n, input logic [1:0] ent, input logic m, input logic clr,
                      input logic rst, input logic [1:0] e_est, input logic [1:0] e_sub,
                      input logic [1:0] e_baj, input logic [15:0] e_cnt);
    vec_t v;
    v.ent = ent; v.m = m; v.clr = clr; v.rst = rst;
    v.e_est = e_est; v.e_sub = e_sub; v.e_baj = e_baj; v.e_cnt = e_cnt;
    for (int k = 0; k < n; k++) tab.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // T alternating 00/11 patterns against estables=01 yield exactly T aborts once settled.
  task automatic burst(input int t);
    for (int j = 0; j < t; j++) begin
      entradas = j[0] ? 2'b11 : 2'b00;
      tick();
    end
    entradas = 2'b01;
    repeat (3) tick();
  endtask

  initial begin
    reset = 1'b1; entradas = 2'b11; muestreo = 1'b1; limpiar_rebotes = 1'b0;

    // Reset then release with both inputs high
    push(3, 2'b11, 1, 0, 1, 2'b00, 2'b00, 2'b00, 16'd0);
    push(5, 2'b11, 1, 0, 0, 2'b00, 2'b00, 2'b00, 16'd0);
    push(1, 2'b11, 1, 0, 0, 2'b11, 2'b11, 2'b00, 16'd0);
    push(1, 2'b11, 1, 0, 0, 2'b11, 2'b00, 2'b00, 16'd0);
    // Clean fall then clean rise on channel 0
    push(5, 2'b10, 1, 0, 0, 2'b11, 2'b00, 2'b00, 16'd0);
    push(1, 2'b10, 1, 0, 0, 2'b10, 2'b00, 2'b01, 16'd0);
    push(1, 2'b10, 1, 0, 0, 2'b10, 2'b00, 2'b00, 16'd0);
    push(5, 2'b11, 1, 0, 0, 2'b10, 2'b00, 2'b00, 16'd0);
    push(1, 2'b11, 1, 0, 0, 2'b11, 2'b01, 2'b00, 16'd0);
    push(1, 2'b11, 1, 0, 0, 2'b11, 2'b00, 2'b00, 16'd0);
    // Three-cycle glitch on channel 0, then on both channels together
    push(3, 2'b10, 1, 0, 0, 2'b11, 2'b00, 2'b00, 16'd0);
    push(2, 2'b11, 1, 0, 0, 2'b11, 2'b00, 2'b00, 16'd0);
    push(2, 2'b11, 1, 0, 0, 2'b11, 2'b00, 2'b00, 16'd1);
    push(3, 2'b00, 1, 0, 0, 2'b11, 2'b00, 2'b00, 16'd1);
    push(2, 2'b11, 1, 0, 0, 2'b11, 2'b00, 2'b00, 16'd1);
    push(2, 2'b11, 1, 0, 0, 2'b11, 2'b00, 2'b00, 16'd2);
    // Strobe every other cycle, channel 1 falls
    for (int k = 0; k < 8; k++)
      push(1, 2'b01, (k % 2 == 0), 0, 0, 2'b11, 2'b00, 2'b00, 16'd2);
    push(1, 2'b01, 1, 0, 0, 2'b01, 2'b00, 2'b10, 16'd2);
    push(1, 2'b01, 0, 0, 0, 2'b01, 2'b00, 2'b00, 16'd2);

    for (int i = 0; i < tab.size(); i++) begin
      entradas = tab[i].ent; muestreo = tab[i].m;
      limpiar_rebotes = tab[i].clr; reset = tab[i].rst;
      tick();
      chk($sformatf("v%0d estables", i), {14'd0, estables}, {14'd0, tab[i].e_est});
      chk($sformatf("v%0d flanco_subida", i), {14'd0, flanco_subida}, {14'd0, tab[i].e_sub});
      chk($sformatf("v%0d flanco_bajada", i), {14'd0, flanco_bajada}, {14'd0, tab[i].e_baj});
      chk($sformatf("v%0d cuenta_rebotes", i), cuenta_rebotes, tab[i].e_cnt);
    end

    // Clear, preload to FFFE, then saturate
    muestreo = 1'b1; entradas = 2'b01; limpiar_rebotes = 1'b1;
    tick();
    chk("clear", cuenta_rebotes, 16'd0);
    limpiar_rebotes = 1'b0;
    burst(65534);
    chk("preload FFFE", cuenta_rebotes, 16'hFFFE);
    chk("preload estables", {14'd0, estables}, 16'h0001);
    burst(2);
    chk("saturate", cuenta_rebotes, 16'hFFFF);
    burst(2);
    chk("saturate hold", cuenta_rebotes, 16'hFFFF);

    // Clear in the same cycle as an abort
    entradas = 2'b00; tick();
    entradas = 2'b01; tick();
    tick();
    limpiar_rebotes = 1'b1; tick();
    chk("clear vs abort", cuenta_rebotes, 16'd0);
    limpiar_rebotes = 1'b0; tick();
    chk("clear vs abort after", cuenta_rebotes, 16'd0);

    // Reset while channel 1 rise is pending with cnt=2
    entradas = 2'b11;
    repeat (4) tick();
    chk("pending estables", {14'd0, estables}, 16'h0001);
    reset = 1'b1; tick();
    chk("midreset estables", {14'd0, estables}, 16'h0000);
    chk("midreset subida", {14'd0, flanco_subida}, 16'h0000);
    chk("midreset bajada", {14'd0, flanco_bajada}, 16'h0000);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("restart%0d estables", k), {14'd0, estables}, 16'h0000);
      chk($sformatf("restart%0d subida", k), {14'd0, flanco_subida}, 16'h0000);
    end
    tick();
    chk("restart accept estables", {14'd0, estables}, 16'h0003);
    chk("restart accept subida", {14'd0, flanco_subida}, 16'h0003);
    chk("restart cuenta", cuenta_rebotes, 16'd0);
    tick();
    chk("restart subida drop", {14'd0, flanco_subida}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
